// File: rtl/multibyte_add_seq.sv
// Multi-byte adder sequencer: one shared 8-bit add slice, LSB byte first, carry chained.
// Optional subtract mode enabled by macro ADD_SEQ_SUB_EN (adds 'sub' input port).
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | one byte added per cycle, busy=1
// DONE  | result just registered, done=1, ready=1 (back-to-back start allowed)
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef ADD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    input  logic [8*NBYTES-1:0]   A,
    input  logic [8*NBYTES-1:0]   B,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   ADD_Out,
    output logic                  CarryOut
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  work;
    logic [W-1:0]  work_next;
    logic [IW-1:0] idx;
    logic          carry;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [8:0]    sum;
    logic          sub_sel;

`ifdef ADD_SEQ_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    // Byte select and work-register merge share the same idx decode.
    always_comb begin
        a_byte    = 8'd0;
        b_byte    = 8'd0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                a_byte = op_a[i*8 +: 8];
                b_byte = op_b[i*8 +: 8];
            end
        end
        sum       = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};
        work_next = work;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                work_next[i*8 +: 8] = sum[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            work     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            ADD_Out  <= '0;
            CarryOut <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= A;
                        op_b  <= sub_sel ? ~B : B;
                        carry <= sub_sel;
                        idx   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= sum[8];
                    if (idx == LAST) begin
                        idx      <= '0;
                        ADD_Out  <= work_next;
                        CarryOut <= sum[8];
                        state    <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed self-checking bench for multibyte_add_seq (NBYTES=4); subtract vectors under ADD_SEQ_SUB_EN.
module tb_multibyte_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] ADD_Out;
    logic         CarryOut;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] held_out;
    logic         held_c;

    always #5 clk = ~clk;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef ADD_SEQ_SUB_EN
        .sub      (sub),
`endif
        .A        (A),
        .B        (B),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .ADD_Out  (ADD_Out),
        .CarryOut (CarryOut)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs change just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic r, input logic b, input logic d);
        sample();
        chk({tag, ".ready"}, {63'd0, ready}, {63'd0, r});
        chk({tag, ".busy"},  {63'd0, busy},  {63'd0, b});
        chk({tag, ".done"},  {63'd0, done},  {63'd0, d});
    endtask

    // Current cycle is cycle 0 with start driven; returns in the done cycle after checking it.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] exp_out, input logic exp_c);
        A = a; B = b; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        A = '1; B = '1; sub = ~s;
        for (int i = 1; i <= NB; i++) begin
            chk_status($sformatf("%s.run%0d", tag, i), 1'b0, 1'b1, 1'b0);
            chk({tag, ".hold_out"}, {32'd0, ADD_Out}, {32'd0, held_out});
            chk({tag, ".hold_c"}, {63'd0, CarryOut}, {63'd0, held_c});
            tick();
        end
        chk_status({tag, ".donecyc"}, 1'b1, 1'b0, 1'b1);
        chk({tag, ".out"}, {32'd0, ADD_Out}, {32'd0, exp_out});
        chk({tag, ".carry"}, {63'd0, CarryOut}, {63'd0, exp_c});
        held_out = exp_out;
        held_c   = exp_c;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        held_out = '0; held_c = 1'b0;

        // 1. reset
        tick(); tick();
        chk_status("reset", 1'b1, 1'b0, 1'b0);
        chk("reset.out", {32'd0, ADD_Out}, 64'd0);
        chk("reset.carry", {63'd0, CarryOut}, 64'd0);
        rst = 1'b0;
        tick();
        chk_status("idle", 1'b1, 1'b0, 1'b0);

        // 2. carry across byte boundary
        run_op("t2", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
        tick();
        chk_status("t2.idle", 1'b1, 1'b0, 1'b0);

        // 3. full carry chain then back-to-back start in DONE cycle
        run_op("t3a", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        run_op("t3b", 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0005, 1'b0);
        tick();

        // 4. start while busy is ignored
        A = 32'd1; B = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk_status("t4.c1", 1'b0, 1'b1, 1'b0);
        chk("t4.hold1", {32'd0, ADD_Out}, 64'h5);
        tick();
        A = 32'd9; B = 32'd9; start = 1'b1;
        chk_status("t4.c2", 1'b0, 1'b1, 1'b0);
        chk("t4.hold2", {32'd0, ADD_Out}, 64'h5);
        tick();
        start = 1'b0;
        chk_status("t4.c3", 1'b0, 1'b1, 1'b0);
        chk("t4.hold3", {32'd0, ADD_Out}, 64'h5);
        tick();
        chk_status("t4.c4", 1'b0, 1'b1, 1'b0);
        chk("t4.hold4", {32'd0, ADD_Out}, 64'h5);
        tick();
        chk_status("t4.c5", 1'b1, 1'b0, 1'b1);
        chk("t4.out", {32'd0, ADD_Out}, 64'h2);
        chk("t4.carry", {63'd0, CarryOut}, 64'd0);
        tick();
        chk_status("t4.idle", 1'b1, 1'b0, 1'b0);
        held_out = 32'h2; held_c = 1'b0;

        // 5. reset in cycle 3 of a RUN aborts it
        A = 32'h10; B = 32'h20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk_status("t5.rst", 1'b1, 1'b0, 1'b0);
        chk("t5.out", {32'd0, ADD_Out}, 64'd0);
        chk("t5.carry", {63'd0, CarryOut}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_status($sformatf("t5.nodone%0d", i), 1'b1, 1'b0, 1'b0);
        end
        held_out = '0; held_c = 1'b0;
        tick();
        run_op("t5b", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        tick();
        run_op("t5c", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        tick();
        run_op("t5d", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0);
        tick();

`ifdef ADD_SEQ_SUB_EN
        // 6. subtract mode
        run_op("t6a", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0);
        tick();
        run_op("t6b", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1);
        tick();
        run_op("t6c", 32'd7, 32'd5, 1'b0, 32'h0000_000C, 1'b0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
